fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
Program-counter and fetch-control stage that sits directly upstream of the instruction memory in the single-cycle RISC-V core.
- Holds the architectural PC and drives the word index into the instruction memory.
- Accepts the returned instruction and pre-decodes JAL so the jump redirects immediately.
- Takes branch/JALR redirects from execute, buffers a redirect that arrives during a stall, and halts on fetch faults.

Parameters:
XLEN, 32, data/address width
IMEM_DEPTH, 32, instruction memory depth in words
AW, $clog2(IMEM_DEPTH), word-index width
RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hold PC this cycle
redirect_valid_i  in  1  execute requests PC change (taken BEQ, JALR)
redirect_target_i  in  XLEN  byte target for redirect
instr_i  in  32  instruction returned by instruction memory (combinational read of imem_addr_o)
imem_addr_o  out  AW  word index = pc[AW+1:2]
pc_o  out  XLEN  current PC (byte address)
pc_plus4_o  out  XLEN  pc_o + 4, for JAL/JALR link
instr_o  out  32  instr_i when fetch_valid_o, else 32'h0000_0013 (NOP)
fetch_valid_o  out  1  instr_o is a real instruction
halted_o  out  1  unit is in HALT
err_o  out  2  fault code: 0 none, 1 misaligned target, 2 out-of-range target

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=BOOT, pending redirect cleared.
  - Outputs during reset: fetch_valid_o=0, halted_o=0, err_o=0.
  - imem_addr_o follows pc; instr_o=NOP.
  - Reset asserted mid-operation aborts everything immediately, including a pending redirect or a HALT.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle after rst deasserts; fetch_valid_o=0; PC unchanged; next state is RUN.
  - RUN: fetch_valid_o = !stall_i; PC updates each rising edge per the priority list below.
  - HALT: PC frozen, fetch_valid_o=0, halted_o=1, err_o held; the state is left only by rst.
- Next-PC priority in RUN, highest first:
  1. stall_i=1: PC holds. A redirect_valid_i seen during the stall is latched into a one-entry pending buffer. A later redirect during the same stall overwrites the buffer.
  2. A valid pending redirect: apply it, clear the buffer. A live redirect_valid_i in that same cycle wins over the pending entry.
  3. redirect_valid_i: pc <= redirect_target_i.
  4. JAL pre-decode, when instr_i[6:0]==7'b1101111: pc <= pc + sext({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}).
  5. Otherwise pc <= pc + 4.
- Arithmetic:
  - All adds are XLEN-bit modulo 2^XLEN.
  - The JAL immediate is 21 bits, sign-extended.
  - pc_plus4_o wraps the same way.
- Fault check applies to every candidate next PC, before it is committed:
  - If bits [1:0] != 0, it is misaligned: err=1.
  - Else if next PC >= 4*IMEM_DEPTH (unsigned), it is out of range: err=2.
  - On a fault: PC is not updated; state goes to HALT on that edge; err_o is registered.
  - Misaligned is checked before out-of-range.
- The sequential PC increment from the last word (4*IMEM_DEPTH-4) is out of range, so it halts.
- Latency:
  - imem_addr_o is combinational from the PC register.
  - A redirect takes effect on the next edge; the new instruction is visible one cycle after redirect_valid_i.
- No flush signal: single-cycle core, the instruction fetched in the redirect cycle is the one being executed.

Decomposition:
- Shared package rv_pkg holds:
  - OPC_JAL=7'b1101111, OPC_BRANCH=7'b1100011, OPC_JALR=7'b1100111.
  - NOP_INSTR=32'h00000013.
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - err code constants.
- One sub-module, jal_imm_decode: combinational instr -> sign-extended J-immediate plus an is_jal flag. Everything else stays in the top module.

Test Plan:
1. Reset release with RESET_PC=0 and no redirects -> BOOT for one cycle (fetch_valid_o=0), then pc_o 0x0, 0x4, 0x8, ... with imem_addr_o 0, 1, 2.
2. instr_i=32'h008000EF (jal x1,8) fetched at pc 0x10 -> next pc_o=0x18, imem_addr_o=6; pc_plus4_o was 0x14 during the JAL cycle.
3. instr_i=32'h00A0006F (JAL offset +10) at pc 0x18 -> target 0x22 is misaligned -> halted_o=1, err_o=1, pc_o stays 0x18; assert rst -> pc_o=0x0, err_o=0.
4. instr_i=32'hF00FF06F at pc 0x3C -> target 0xFFFFF73C is out of range -> halted_o=1, err_o=2.
5. stall_i=1 for 3 cycles at pc 0x20 while redirect_valid_i pulses with target 0x08 in the 2nd cycle -> pc_o holds 0x20; after stall_i drops, pc_o=0x08 on the next edge.
6. pc reaches 0x7C (last word, IMEM_DEPTH=32) with no redirect -> halted_o=1, err_o=2; a redirect_valid_i to 0x00 in that same cycle instead gives pc_o=0x00 and no halt.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage of the single-cycle RISC-V core.
// Holds opcode constants, the canonical NOP encoding, the fetch FSM state
// type, fault codes, and the fault classification helper used on every
// candidate next PC.
package rv_pkg;

  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam logic [1:0]  ERR_NONE       = 2'd0;
  localparam logic [1:0]  ERR_MISALIGNED = 2'd1;
  localparam logic [1:0]  ERR_RANGE      = 2'd2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Classify a candidate PC. Misalignment is reported ahead of range so a
  // wild, unaligned target always reads as err 1.
  function automatic logic [1:0] pc_fault(input logic [31:0] addr,
                                          input logic [31:0] limit);
    logic [1:0] code_s;
    if (addr[1:0] != 2'b00) begin
      code_s = ERR_MISALIGNED;
    end else if (addr >= limit) begin
      code_s = ERR_RANGE;
    end else begin
      code_s = ERR_NONE;
    end
    return code_s;
  endfunction

endpackage

// File: rtl/jal_imm_decode.sv
// JAL pre-decoder.
// Ports:
//   opcode   in  7      instr[6:0]
//   imm_bits in  20     instr[31:12] (the J-type immediate field)
//   imm      out XLEN   sign-extended byte offset of the jump
//   is_jal   out 1      opcode is JAL
// Purely combinational; only the instruction bits it needs are passed in.
module jal_imm_decode
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      opcode,
  input  logic [19:0]     imm_bits,
  output logic [XLEN-1:0] imm,
  output logic            is_jal
);

  logic [20:0] imm21_s;

  // Reassemble the scrambled J-type immediate; imm_bits[k] is instr[k+12].
  always_comb begin
    imm21_s = {imm_bits[19],      // instr[31]    -> imm[20]
               imm_bits[7:0],     // instr[19:12] -> imm[19:12]
               imm_bits[8],       // instr[20]    -> imm[11]
               imm_bits[18:9],    // instr[30:21] -> imm[10:1]
               1'b0};
  end

  assign imm    = {{(XLEN-21){imm21_s[20]}}, imm21_s};
  assign is_jal = (opcode == OPC_JAL);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control sitting directly in front of the
// instruction memory.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   stall_i             hold the PC this cycle
//   redirect_valid_i    execute requests a PC change
//   redirect_target_i   byte target of that change
//   instr_i             instruction read combinationally at imem_addr_o
//   imem_addr_o         word index pc[AW+1:2]
//   pc_o, pc_plus4_o    current PC and its link value
//   instr_o             instr_i when fetch_valid_o, otherwise NOP
//   fetch_valid_o       instr_o is a real instruction
//   halted_o, err_o     halt flag and latched fault code
// A redirect arriving while stalled is parked in a one-entry buffer and
// applied when the stall releases, unless a live redirect arrives then.
// Any fault on a candidate next PC freezes the unit until reset.
module fetch_pc_unit
  import rv_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 32,
  parameter int              AW         = $clog2(IMEM_DEPTH),
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic [31:0]     instr_i,
  output logic [AW-1:0]   imem_addr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [31:0]     instr_o,
  output logic            fetch_valid_o,
  output logic            halted_o,
  output logic [1:0]      err_o
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(4 * IMEM_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  fetch_state_t    state_r,       state_nxt_s;
  logic [XLEN-1:0] pc_r,          pc_nxt_s;
  logic            pend_valid_r,  pend_valid_nxt_s;
  logic [XLEN-1:0] pend_target_r, pend_target_nxt_s;
  logic [1:0]      err_r,         err_nxt_s;

  logic [XLEN-1:0] jal_imm_s;
  logic            is_jal_s;
  logic [XLEN-1:0] cand_pc_s;
  logic [1:0]      cand_fault_s;
  logic            fetch_valid_s;

  jal_imm_decode #(
    .XLEN (XLEN)
  ) u_jal_imm_decode (
    .opcode   (instr_i[6:0]),
    .imm_bits (instr_i[31:12]),
    .imm      (jal_imm_s),
    .is_jal   (is_jal_s)
  );

  // Candidate next PC when not stalled: live redirect, then pending
  // redirect, then JAL, then sequential.
  always_comb begin
    cand_pc_s = pc_r + PC_STEP;
    if (redirect_valid_i) begin
      cand_pc_s = redirect_target_i;
    end else if (pend_valid_r) begin
      cand_pc_s = pend_target_r;
    end else if (is_jal_s) begin
      cand_pc_s = pc_r + jal_imm_s;
    end else begin
      cand_pc_s = pc_r + PC_STEP;
    end
    cand_fault_s = pc_fault(cand_pc_s, PC_LIMIT);
  end

  // FSM next-state, PC commit, pending-redirect buffer and fault capture.
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    pend_valid_nxt_s  = pend_valid_r;
    pend_target_nxt_s = pend_target_r;
    err_nxt_s         = err_r;
    case (state_r)
      BOOT: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        if (stall_i) begin
          // A later redirect in the same stall simply overwrites the entry.
          if (redirect_valid_i) begin
            pend_valid_nxt_s  = 1'b1;
            pend_target_nxt_s = redirect_target_i;
          end else begin
            pend_valid_nxt_s  = pend_valid_r;
          end
        end else begin
          pend_valid_nxt_s = 1'b0;
          if (cand_fault_s != ERR_NONE) begin
            // PC stays on the instruction that produced the bad target.
            state_nxt_s = HALT;
            err_nxt_s   = cand_fault_s;
          end else begin
            pc_nxt_s    = cand_pc_s;
          end
        end
      end
      HALT: begin
        state_nxt_s = HALT;
      end
      default: begin
        state_nxt_s = HALT;
      end
    endcase
  end

  // State registers; reset aborts any pending redirect or halt at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC;
      pend_valid_r  <= 1'b0;
      pend_target_r <= '0;
      err_r         <= ERR_NONE;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      pend_valid_r  <= pend_valid_nxt_s;
      pend_target_r <= pend_target_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

  assign fetch_valid_s = (state_r == RUN) && !stall_i;

  assign imem_addr_o   = pc_r[AW+1:2];
  assign pc_o          = pc_r;
  assign pc_plus4_o    = pc_r + PC_STEP;
  assign fetch_valid_o = fetch_valid_s;
  assign instr_o       = fetch_valid_s ? instr_i : NOP_INSTR;
  assign halted_o      = (state_r == HALT);
  assign err_o         = err_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a table of per-cycle vectors followed by
// hand-written reset/fault sequences. Inputs change on the falling edge and
// outputs are compared 1 time unit later, well away from the rising edge.
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0010_0093;
  localparam logic [31:0] JAL8  = 32'h0080_00EF;
  localparam logic [31:0] JAL10 = 32'h00A0_006F;
  localparam logic [31:0] JALNG = 32'hF00F_F06F;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic [31:0] instr_i;
  logic [4:0]  imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] instr_o;
  logic        fetch_valid_o;
  logic        halted_o;
  logic [1:0]  err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [1:0]  err;
    logic [31:0] instr_out;
  } vec_t;

  vec_t vecs[$];

  fetch_pc_unit #(
    .XLEN       (32),
    .IMEM_DEPTH (32),
    .AW         (5),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .instr_i           (instr_i),
    .imem_addr_o       (imem_addr_o),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .instr_o           (instr_o),
    .fetch_valid_o     (fetch_valid_o),
    .halted_o          (halted_o),
    .err_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic stall, input logic rv,
                              input logic [31:0] tgt, input logic [31:0] instr,
                              input logic [31:0] pc, input logic valid,
                              input logic halted, input logic [1:0] err,
                              input logic [31:0] instr_out);
    vec_t v;
    v.stall = stall; v.rv = rv; v.tgt = tgt; v.instr = instr;
    v.pc = pc; v.valid = valid; v.halted = halted; v.err = err;
    v.instr_out = instr_out;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one cycle's inputs, compare outputs, then advance to the next falling edge.
  task automatic run_vec(input string nm, input vec_t v);
    logic [31:0] exp_addr;
    stall_i           = v.stall;
    redirect_valid_i  = v.rv;
    redirect_target_i = v.tgt;
    instr_i           = v.instr;
    #1;
    exp_addr = {27'd0, v.pc[6:2]};
    chk({nm, " pc"},     pc_o,                  v.pc);
    chk({nm, " addr"},   {27'd0, imem_addr_o},  exp_addr);
    chk({nm, " plus4"},  pc_plus4_o,            v.pc + 32'd4);
    chk({nm, " valid"},  {31'd0, fetch_valid_o}, {31'd0, v.valid});
    chk({nm, " halted"}, {31'd0, halted_o},     {31'd0, v.halted});
    chk({nm, " err"},    {30'd0, err_o},        {30'd0, v.err});
    chk({nm, " instr"},  instr_o,               v.instr_out);
    @(negedge clk);
  endtask

  // Assert reset on a falling edge, check the reset outputs, release on the next one.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = 32'd0;
    instr_i = ADDI;
    #1;
    chk({nm, " rst pc"},     pc_o,                   32'h0000_0000);
    chk({nm, " rst addr"},   {27'd0, imem_addr_o},   32'd0);
    chk({nm, " rst valid"},  {31'd0, fetch_valid_o}, 32'd0);
    chk({nm, " rst halted"}, {31'd0, halted_o},      32'd0);
    chk({nm, " rst err"},    {30'd0, err_o},         32'd0);
    chk({nm, " rst instr"},  instr_o,                NOP);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = 32'd0;
    instr_i = ADDI;

    // stall rv tgt instr | pc valid halted err instr_o
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h00, 1'b0, 1'b0, 2'd0, NOP));   // BOOT
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h04, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h08, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h0C, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, JAL8,  32'h10, 1'b1, 1'b0, 2'd0, JAL8));  // jal +8
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h18, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h1C, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b1, 1'b0, 32'h00, ADDI,  32'h20, 1'b0, 1'b0, 2'd0, NOP));   // stall 1
    vecs.push_back(mk(1'b1, 1'b1, 32'h08, ADDI,  32'h20, 1'b0, 1'b0, 2'd0, NOP));   // stall 2 + redirect
    vecs.push_back(mk(1'b1, 1'b0, 32'h00, ADDI,  32'h20, 1'b0, 1'b0, 2'd0, NOP));   // stall 3
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h20, 1'b1, 1'b0, 2'd0, ADDI));  // pending applies
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h08, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b1, 1'b1, 32'h40, ADDI,  32'h0C, 1'b0, 1'b0, 2'd0, NOP));
    vecs.push_back(mk(1'b1, 1'b1, 32'h44, ADDI,  32'h0C, 1'b0, 1'b0, 2'd0, NOP));   // overwrite
    vecs.push_back(mk(1'b0, 1'b1, 32'h30, ADDI,  32'h0C, 1'b1, 1'b0, 2'd0, ADDI));  // live beats pending
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h30, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h34, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b1, 32'h7C, ADDI,  32'h38, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b1, 32'h00, ADDI,  32'h7C, 1'b1, 1'b0, 2'd0, ADDI));  // last word + redirect
    vecs.push_back(mk(1'b0, 1'b1, 32'h7C, ADDI,  32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h7C, 1'b1, 1'b0, 2'd0, ADDI));  // falls off the end
    vecs.push_back(mk(1'b0, 1'b0, 32'h00, ADDI,  32'h7C, 1'b0, 1'b1, 2'd2, NOP));
    vecs.push_back(mk(1'b0, 1'b1, 32'h10, ADDI,  32'h7C, 1'b0, 1'b1, 2'd2, NOP));   // halt ignores redirect

    #2;
    chk("init pc",     pc_o,                   32'h0000_0000);
    chk("init valid",  {31'd0, fetch_valid_o}, 32'd0);
    chk("init halted", {31'd0, halted_o},      32'd0);
    chk("init err",    {30'd0, err_o},         32'd0);
    chk("init instr",  instr_o,                NOP);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Misaligned JAL target halts with err 1; reset clears the halt.
    do_reset("mis");
    run_vec("mis boot", mk(1'b0, 1'b0, 32'h00, ADDI,  32'h00, 1'b0, 1'b0, 2'd0, NOP));
    run_vec("mis go",   mk(1'b0, 1'b1, 32'h18, ADDI,  32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    run_vec("mis jal",  mk(1'b0, 1'b0, 32'h00, JAL10, 32'h18, 1'b1, 1'b0, 2'd0, JAL10));
    run_vec("mis halt", mk(1'b0, 1'b0, 32'h00, ADDI,  32'h18, 1'b0, 1'b1, 2'd1, NOP));

    // Backward JAL wraps to a huge address: out of range, err 2.
    do_reset("rng");
    run_vec("rng boot", mk(1'b0, 1'b0, 32'h00, ADDI,  32'h00, 1'b0, 1'b0, 2'd0, NOP));
    run_vec("rng go",   mk(1'b0, 1'b1, 32'h3C, ADDI,  32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    run_vec("rng jal",  mk(1'b0, 1'b0, 32'h00, JALNG, 32'h3C, 1'b1, 1'b0, 2'd0, JALNG));
    run_vec("rng halt", mk(1'b0, 1'b0, 32'h00, ADDI,  32'h3C, 1'b0, 1'b1, 2'd2, NOP));

    // Target both unaligned and out of range reports misaligned.
    do_reset("prio");
    run_vec("prio boot", mk(1'b0, 1'b0, 32'h00, ADDI, 32'h00, 1'b0, 1'b0, 2'd0, NOP));
    run_vec("prio go",   mk(1'b0, 1'b1, 32'h81, ADDI, 32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    run_vec("prio halt", mk(1'b0, 1'b0, 32'h00, ADDI, 32'h00, 1'b0, 1'b1, 2'd1, NOP));

    // Reset discards a redirect parked during a stall.
    do_reset("pend");
    run_vec("pend boot",  mk(1'b0, 1'b0, 32'h00, ADDI, 32'h00, 1'b0, 1'b0, 2'd0, NOP));
    run_vec("pend park",  mk(1'b1, 1'b1, 32'h40, ADDI, 32'h00, 1'b0, 1'b0, 2'd0, NOP));
    do_reset("pend2");
    run_vec("pend boot2", mk(1'b0, 1'b0, 32'h00, ADDI, 32'h00, 1'b0, 1'b0, 2'd0, NOP));
    run_vec("pend run",   mk(1'b0, 1'b0, 32'h00, ADDI, 32'h00, 1'b1, 1'b0, 2'd0, ADDI));
    run_vec("pend seq",   mk(1'b0, 1'b0, 32'h00, ADDI, 32'h04, 1'b1, 1'b0, 2'd0, ADDI));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
